// File: rtl/jtvigil_gfx_pkg.sv
// Shared definitions for the Vigilante graphics ROM arbiter: arbiter states,
// slot numbering and default bus widths.
package jtvigil_gfx_pkg;

  localparam int AW_DEF  = 18;
  localparam int DW_DEF  = 32;
  localparam int TMO_DEF = 255;
  localparam int NSLOT   = 3;

  localparam logic [1:0] SLOT_SCR1 = 2'd0;
  localparam logic [1:0] SLOT_SCR2 = 2'd1;
  localparam logic [1:0] SLOT_OBJ  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // (a + k) mod 3 for slot indices and offsets in 0..2
  function automatic logic [1:0] slot_add(input logic [1:0] a, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/jtvigil_gfx_slot.sv
// One-entry address/data cache for a single fetcher; ok is a pure hit test
// against the registered entry, so an address change drops ok immediately.
module jtvigil_gfx_slot
  import jtvigil_gfx_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic [DW-1:0] data,
  output logic          ok
);

  logic          valid_reg;
  logic [AW-1:0] tag_reg;
  logic [DW-1:0] data_reg;

  // flush has priority, so a fill arriving in the same cycle is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_addr;
      data_reg  <= fill_data;
    end
  end

  assign ok   = cs & valid_reg & (tag_reg == addr);
  assign data = data_reg;

endmodule

// File: rtl/jtvigil_gfx_arb.sv
// Round-robin arbiter sharing the graphics SDRAM read port between scroll 1,
// scroll 2 and object fetchers, with per-slot caches and a port watchdog.
module jtvigil_gfx_arb
  import jtvigil_gfx_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          slot0_cs,
  input  logic [AW-1:0] slot0_addr,
  output logic [DW-1:0] slot0_data,
  output logic          slot0_ok,
  input  logic          slot1_cs,
  input  logic [AW-1:0] slot1_addr,
  output logic [DW-1:0] slot1_data,
  output logic          slot1_ok,
  input  logic          slot2_cs,
  input  logic [AW-1:0] slot2_addr,
  output logic [DW-1:0] slot2_data,
  output logic          slot2_ok,
  output logic          sdram_cs,
  output logic [AW-1:0] sdram_addr,
  input  logic [DW-1:0] sdram_data,
  input  logic          sdram_ok,
  output logic          tmo_err
);

  state_t        state_reg, state_next;
  logic [1:0]    gnt_reg, gnt_next;
  logic [1:0]    rr_reg, rr_next;
  logic [7:0]    wdog_reg, wdog_next;
  logic          sdram_cs_reg, sdram_cs_next;
  logic [AW-1:0] sdram_addr_reg, sdram_addr_next;
  logic          tmo_err_reg, tmo_err_next;
  logic          discard_reg, discard_next;
  logic          cs_d_reg;

  logic [NSLOT-1:0] cs_vec, ok_vec, miss_vec, fill_vec;
  logic [AW-1:0]    addr_arr [NSLOT];
  logic [DW-1:0]    data_arr [NSLOT];

  logic       accept, timeout, found;
  logic [1:0] pick, idx;

  assign cs_vec[SLOT_SCR1]   = slot0_cs;
  assign cs_vec[SLOT_SCR2]   = slot1_cs;
  assign cs_vec[SLOT_OBJ]    = slot2_cs;
  assign addr_arr[SLOT_SCR1] = slot0_addr;
  assign addr_arr[SLOT_SCR2] = slot1_addr;
  assign addr_arr[SLOT_OBJ]  = slot2_addr;

  // ok in the first BUSY cycle may be left over from the previous request
  assign accept  = (state_reg == ST_BUSY) & sdram_ok & cs_d_reg;
  assign timeout = (state_reg == ST_BUSY) & ~accept & (wdog_reg == 8'(TMO - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign miss_vec[gi] = cs_vec[gi] & ~ok_vec[gi];
      assign fill_vec[gi] = accept & ~discard_reg & (gnt_reg == 2'(gi));

      jtvigil_gfx_slot #(.AW(AW), .DW(DW)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cs        (cs_vec[gi]),
        .addr      (addr_arr[gi]),
        .fill      (fill_vec[gi]),
        .fill_addr (sdram_addr_reg),
        .fill_data (sdram_data),
        .data      (data_arr[gi]),
        .ok        (ok_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    rr_next         = rr_reg;
    wdog_next       = wdog_reg;
    sdram_cs_next   = sdram_cs_reg;
    sdram_addr_next = sdram_addr_reg;
    tmo_err_next    = tmo_err_reg;
    discard_next    = discard_reg;
    found           = 1'b0;
    pick            = rr_reg;
    idx             = rr_reg;

    case (state_reg)
      ST_IDLE: begin
        // scan from the far end so the slot nearest rr wins
        for (int k = NSLOT - 1; k >= 0; k--) begin
          idx = slot_add(rr_reg, 2'(k));
          if (miss_vec[idx]) begin
            pick  = idx;
            found = 1'b1;
          end
        end
        if (found) begin
          gnt_next        = pick;
          sdram_addr_next = addr_arr[pick];
          sdram_cs_next   = 1'b1;
          wdog_next       = '0;
          rr_next         = slot_add(pick, 2'd1);
          state_next      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) discard_next = 1'b1;
        if (accept) begin
          sdram_cs_next = 1'b0;
          state_next    = ST_GAP;
        end else if (timeout) begin
          sdram_cs_next = 1'b0;
          tmo_err_next  = 1'b1;
          state_next    = ST_GAP;
        end else begin
          wdog_next = wdog_reg + 8'd1;
        end
      end
      ST_GAP: begin
        sdram_cs_next = 1'b0;
        discard_next  = 1'b0;
        state_next    = ST_IDLE;
      end
      default: begin
        sdram_cs_next = 1'b0;
        state_next    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= '0;
      rr_reg         <= '0;
      wdog_reg       <= '0;
      sdram_cs_reg   <= 1'b0;
      sdram_addr_reg <= '0;
      tmo_err_reg    <= 1'b0;
      discard_reg    <= 1'b0;
      cs_d_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      rr_reg         <= rr_next;
      wdog_reg       <= wdog_next;
      sdram_cs_reg   <= sdram_cs_next;
      sdram_addr_reg <= sdram_addr_next;
      tmo_err_reg    <= tmo_err_next;
      discard_reg    <= discard_next;
      cs_d_reg       <= sdram_cs_reg;
    end
  end

  assign sdram_cs   = sdram_cs_reg;
  assign sdram_addr = sdram_addr_reg;
  assign tmo_err    = tmo_err_reg;
  assign slot0_ok   = ok_vec[SLOT_SCR1];
  assign slot1_ok   = ok_vec[SLOT_SCR2];
  assign slot2_ok   = ok_vec[SLOT_OBJ];
  assign slot0_data = data_arr[SLOT_SCR1];
  assign slot1_data = data_arr[SLOT_SCR2];
  assign slot2_data = data_arr[SLOT_OBJ];

endmodule

// File: tb/tb_jtvigil_gfx_arb.sv
// Bench for jtvigil_gfx_arb: directed corner cases, a hit-logic vector table
// and a randomized run against a cycle-level cache/arbitration model.
module tb_jtvigil_gfx_arb;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          slot0_cs = 1'b0, slot1_cs = 1'b0, slot2_cs = 1'b0;
  logic [AW-1:0] slot0_addr = '0, slot1_addr = '0, slot2_addr = '0;
  logic [DW-1:0] slot0_data, slot1_data, slot2_data;
  logic          slot0_ok, slot1_ok, slot2_ok;
  logic          sdram_cs;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_data = '0;
  logic          sdram_ok = 1'b0;
  logic          tmo_err;

  always #5 clk = ~clk;

  jtvigil_gfx_arb dut (
    .clk(clk), .rst(rst), .flush(flush),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_data(slot0_data), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_data(slot1_data), .slot1_ok(slot1_ok),
    .slot2_cs(slot2_cs), .slot2_addr(slot2_addr), .slot2_data(slot2_data), .slot2_ok(slot2_ok),
    .sdram_cs(sdram_cs), .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_ok(sdram_ok),
    .tmo_err(tmo_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hash(input logic [AW-1:0] a);
    return {a[13:0], a} ^ 32'h5A5A_1234;
  endfunction

  // SDRAM responder controls
  bit          resp_en = 0, resp_stuck = 0, resp_xor = 0, resp_rand = 0, resp_junk = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data = '0;
  int          resp_lat = 2;
  int          cs_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (sdram_cs) cs_cnt++; else cs_cnt = 0;
    if (resp_rand && cs_cnt == 1) resp_lat = $urandom_range(1, 4);
    sdram_ok = resp_stuck | (resp_en & sdram_cs & (cs_cnt >= resp_lat))
             | (resp_junk & ~sdram_cs & ($urandom_range(0, 4) == 0));
    sdram_data = ovr_en ? ovr_data : (hash(sdram_addr) ^ (resp_xor ? 32'(cs_cnt) : 32'd0));
  endtask

  function automatic logic get_ok(input int i);
    case (i)
      0: return slot0_ok;
      1: return slot1_ok;
      default: return slot2_ok;
    endcase
  endfunction

  function automatic logic [DW-1:0] get_data(input int i);
    case (i)
      0: return slot0_data;
      1: return slot1_data;
      default: return slot2_data;
    endcase
  endfunction

  function automatic logic get_cs(input int i);
    case (i)
      0: return slot0_cs;
      1: return slot1_cs;
      default: return slot2_cs;
    endcase
  endfunction

  function automatic logic [AW-1:0] get_addr(input int i);
    case (i)
      0: return slot0_addr;
      1: return slot1_addr;
      default: return slot2_addr;
    endcase
  endfunction

  task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
    case (i)
      0: begin slot0_cs = cs; slot0_addr = a; end
      1: begin slot1_cs = cs; slot1_addr = a; end
      default: begin slot2_cs = cs; slot2_addr = a; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    slot0_cs = 0; slot1_cs = 0; slot2_cs = 0;
    slot0_addr = '0; slot1_addr = '0; slot2_addr = '0;
    resp_en = 0; resp_stuck = 0; resp_xor = 0; resp_rand = 0; resp_junk = 0; ovr_en = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_cs(input logic level, input int budget);
    int n = 0;
    while (sdram_cs !== level && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk(level ? "wait_cs_rise" : "wait_cs_fall", sdram_cs, level);
  endtask

  task automatic wait_ok(input int i, input int budget);
    int n = 0;
    while (get_ok(i) !== 1'b1 && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_ok%0d", i), get_ok(i), 1'b1);
  endtask

  // Reference model: cache contents plus one outstanding transaction
  bit          mvalid [3];
  logic [AW-1:0] mtag [3];
  bit          mbusy, mgap, mdisc;
  int          mcnt, mgnt, mrr;
  logic [AW-1:0] maddr;

  task automatic model_step();
    bit hit [3];
    bit any = 0;
    int g = 0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = get_cs(i) && mvalid[i] && (mtag[i] == get_addr(i));
      chk($sformatf("rnd_ok%0d", i), get_ok(i), hit[i]);
      if (hit[i]) chk($sformatf("rnd_data%0d", i), get_data(i), hash(get_addr(i)));
    end
    chk("rnd_sdram_cs", sdram_cs, mbusy);
    if (mbusy) chk("rnd_sdram_addr", sdram_addr, maddr);

    if (mgap) begin
      mgap = 0;
      mdisc = 0;
    end else if (mbusy) begin
      if (flush) mdisc = 1;
      if (sdram_ok && mcnt > 0) begin
        if (!mdisc) begin
          mvalid[mgnt] = 1;
          mtag[mgnt] = maddr;
        end
        mbusy = 0;
        mgap = 1;
      end else begin
        mcnt++;
        if (mcnt >= 255) begin
          mbusy = 0;
          mgap = 1;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int s;
        s = (mrr + k) % 3;
        if (!any && get_cs(s) && !hit[s]) begin
          any = 1;
          g = s;
        end
      end
      if (any) begin
        mgnt = g;
        maddr = get_addr(g);
        mrr = (g + 1) % 3;
        mbusy = 1;
        mcnt = 0;
      end
    end
    if (flush) for (int i = 0; i < 3; i++) mvalid[i] = 0;
  endtask

  typedef struct {
    logic [2:0]    cs;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    ok;
  } vec_t;

  vec_t vt [6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, hi, low, min_low, lat_n, extra;
    bit prev_cs, seen;
    logic [AW-1:0] seq [$];

    vt[0] = '{cs: 3'b010, a0: 18'h0,     a1: 18'h00123, a2: 18'h0,     ok: 3'b010};
    vt[1] = '{cs: 3'b010, a0: 18'h0,     a1: 18'h00124, a2: 18'h0,     ok: 3'b000};
    vt[2] = '{cs: 3'b000, a0: 18'h0,     a1: 18'h00123, a2: 18'h0,     ok: 3'b000};
    vt[3] = '{cs: 3'b111, a0: 18'h00123, a1: 18'h00123, a2: 18'h00123, ok: 3'b010};
    vt[4] = '{cs: 3'b111, a0: 18'h0,     a1: 18'h00123, a2: 18'h0,     ok: 3'b010};
    vt[5] = '{cs: 3'b010, a0: 18'h0,     a1: 18'h20123, a2: 18'h0,     ok: 3'b000};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_sdram_cs", sdram_cs, 1'b0);
    chk("rst_sdram_addr", sdram_addr, '0);
    chk("rst_tmo_err", tmo_err, 1'b0);
    chk("rst_data", {slot0_data, slot1_data, slot2_data}, '0);
    slot0_cs = 1; slot1_cs = 1; slot2_cs = 1;
    #1;
    chk("rst_ok_invalid", {slot2_ok, slot1_ok, slot0_ok}, 3'b000);
    slot0_cs = 0; slot1_cs = 0; slot2_cs = 0;

    // Single miss on slot1, SDRAM answering on the third cs cycle
    resp_en = 1; resp_lat = 3; ovr_en = 1; ovr_data = 32'hDEADBEEF;
    slot1_cs = 1; slot1_addr = 18'h00123;
    lat_n = 0; seen = 0;
    while (!slot1_ok && lat_n < 20) begin
      tick();
      @(negedge clk);
      lat_n++;
      if (sdram_cs && !seen) begin
        seen = 1;
        chk("t1_sdram_addr", sdram_addr, 18'h00123);
      end
    end
    chk("t1_miss_latency", lat_n, 4);
    chk("t1_ok", slot1_ok, 1'b1);
    chk("t1_data", slot1_data, 32'hDEADBEEF);
    extra = 0;
    repeat (6) begin
      tick();
      @(negedge clk);
      if (sdram_cs) extra++;
    end
    chk("t1_no_refetch", extra, 0);
    slot1_cs = 0;
    tick();
    @(negedge clk);
    slot1_cs = 1;
    #1;
    chk("t1_rehit_0cycle", slot1_ok, 1'b1);
    ovr_en = 0;

    // Hit-logic vectors against the slot1 entry (0x123)
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_slot(0, vt[i].cs[0], vt[i].a0);
      set_slot(1, vt[i].cs[1], vt[i].a1);
      set_slot(2, vt[i].cs[2], vt[i].a2);
      #1;
      chk($sformatf("vec%0d_ok", i), {slot2_ok, slot1_ok, slot0_ok}, vt[i].ok);
      slot0_cs = 0; slot1_cs = 0; slot2_cs = 0;
      tick();
    end
    @(negedge clk);
    chk("vec_no_sdram", sdram_cs, 1'b0);

    // All three slots miss at once: grants 0,1,2 with a gap between
    do_reset();
    resp_en = 1; resp_lat = 2;
    @(negedge clk);
    set_slot(0, 1, 18'h10); set_slot(1, 1, 18'h20); set_slot(2, 1, 18'h30);
    prev_cs = 0; low = 0; min_low = 99; n = 0;
    while (!(slot0_ok && slot1_ok && slot2_ok) && n < 60) begin
      tick();
      @(negedge clk);
      n++;
      if (sdram_cs && !prev_cs) begin
        if (seq.size() > 0 && low < min_low) min_low = low;
        seq.push_back(sdram_addr);
        low = 0;
      end
      if (!sdram_cs) low++;
      prev_cs = sdram_cs;
    end
    chk("t2_n_trans", seq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_addr%0d", i), (i < seq.size()) ? seq[i] : 18'h3FFFF, 18'h10 * (i + 1));
    chk("t2_gap_ge1", (min_low >= 1), 1'b1);
    chk("t2_data0", slot0_data, hash(18'h10));
    chk("t2_data1", slot1_data, hash(18'h20));
    chk("t2_data2", slot2_data, hash(18'h30));

    // Slot0 moves its address while the fetch is in flight
    slot1_cs = 0; slot2_cs = 0;
    resp_lat = 3;
    set_slot(0, 1, 18'h40);
    wait_cs(1, 10);
    chk("t3_first_addr", sdram_addr, 18'h40);
    slot0_addr = 18'h41;
    wait_cs(0, 10);
    chk("t3_ok_low", slot0_ok, 1'b0);
    slot0_addr = 18'h40;
    #1;
    chk("t3_filled_latched", slot0_ok, 1'b1);
    chk("t3_filled_data", slot0_data, hash(18'h40));
    slot0_addr = 18'h41;
    wait_cs(1, 10);
    chk("t3_second_addr", sdram_addr, 18'h41);
    wait_ok(0, 10);
    chk("t3_second_data", slot0_data, hash(18'h41));

    // Flush during slot2 fetch discards the result
    slot0_cs = 0;
    set_slot(2, 1, 18'h50);
    wait_cs(1, 10);
    tick();
    flush = 1;
    @(negedge clk);
    wait_cs(0, 10);
    chk("t4_no_ok", slot2_ok, 1'b0);
    set_slot(0, 1, 18'h41); set_slot(1, 1, 18'h20);
    #1;
    chk("t4_all_invalid", {slot1_ok, slot0_ok}, 2'b00);
    slot0_cs = 0; slot1_cs = 0;
    wait_cs(1, 10);
    chk("t4_refetch_addr", sdram_addr, 18'h50);
    wait_ok(2, 10);
    chk("t4_refetch_data", slot2_data, hash(18'h50));

    // Watchdog: SDRAM never answers
    slot2_cs = 0;
    resp_en = 0;
    set_slot(0, 1, 18'h60);
    wait_cs(1, 10);
    hi = 1;
    while (sdram_cs && hi < 300) begin
      tick();
      @(negedge clk);
      if (sdram_cs) hi++;
    end
    chk("t5_cs_cycles", hi, 255);
    chk("t5_tmo_err", tmo_err, 1'b1);
    chk("t5_no_ok", slot0_ok, 1'b0);
    resp_en = 1; resp_lat = 2;
    low = 1;
    while (!sdram_cs && low < 10) begin
      tick();
      @(negedge clk);
      if (!sdram_cs) low++;
    end
    chk("t5_regrant_gap", low, 2);
    chk("t5_regrant_addr", sdram_addr, 18'h60);
    wait_ok(0, 10);
    chk("t5_tmo_sticky", tmo_err, 1'b1);

    // SDRAM ok stuck high: first BUSY cycle ignored
    do_reset();
    @(negedge clk);
    chk("t6_tmo_cleared", tmo_err, 1'b0);
    resp_stuck = 1; resp_xor = 1;
    set_slot(1, 1, 18'h77);
    n = 0; hi = 0;
    while (!slot1_ok && n < 20) begin
      tick();
      @(negedge clk);
      n++;
      if (sdram_cs) hi++;
    end
    chk("t6_latency", n, 3);
    chk("t6_cs_cycles", hi, 2);
    chk("t6_data_2nd_cycle", slot1_data, hash(18'h77) ^ 32'd2);
    resp_stuck = 0; resp_xor = 0;

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mvalid[i] = 0;
      mtag[i] = '0;
    end
    mbusy = 0; mgap = 0; mdisc = 0; mcnt = 0; mgnt = 0; mrr = 0; maddr = '0;
    resp_en = 1; resp_rand = 1; resp_junk = 1;
    repeat (3000) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        logic c;
        logic [AW-1:0] a;
        c = get_cs(i);
        a = get_addr(i);
        if ($urandom_range(0, 9) == 0) c = ~c;
        if ($urandom_range(0, 6) == 0) a = 18'h100 + 18'($urandom_range(0, 5));
        set_slot(i, c, a);
      end
      flush = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      model_step();
    end
    chk("rnd_tmo_err", tmo_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
